pll_lock_seq: RTL and testbench

- Parametrised lock supervisor and reset sequencer for N_PLL GTP_PLL_E3 wrapper instances.
- Drives each PLL's reset and watches its raw lock with a 2-flop synchroniser.
- Requires lock to stay high for a debounce window, retries a PLL that does not lock in time, and gives up after a set number of retries.
- Releases one downstream domain reset per PLL, after a programmable delay, and reports status.
- Runs on the free-running 50 MHz reference clock that also feeds the PLLs. Sits between board reset and the PLL wrappers.

---
 rtl/pll_lock_pkg.sv | 25 ++
 rtl/pll_lock_chan.sv | 179 +++++++++++++++++
 rtl/pll_lock_seq.sv | 64 ++++++
 tb/tb_pll_lock_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pll_lock_pkg.sv
// Shared types and helpers for the PLL lock supervisor and its per-channel sequencer.
package pll_lock_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int RETRY_W = 4;

  // Width able to hold the largest terminal count, including RELEASE_DLY itself.
  function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                   input int debounce, input int release_dly);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (debounce > m) m = debounce;
    if (release_dly > m) m = release_dly;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One supervised PLL: lock synchroniser, sequencing FSM, shared state counter,
// saturating retry counter and sticky lock-loss flag.
module pll_lock_chan
  import pll_lock_pkg::*;
#(
  parameter int RST_CYCLES   = 32,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int DEBOUNCE     = 1024,
  parameter int RELEASE_DLY  = 16,
  parameter int MAX_RETRY    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lock_raw,
  input  logic               restart,
  input  logic               lost_clr,
  output logic               pll_rst_o,
  output logic               domain_rst,
  output logic               locked,
  output logic               locked_nx,
  output logic               lock_lost,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, DEBOUNCE, RELEASE_DLY);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]   REL_CNT   = CNT_W'(RELEASE_DLY);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_SAT = {RETRY_W{1'b1}};

  pll_state_e         state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
  logic [RETRY_W-1:0] retry_r, retry_nx_s, retry_inc_s;
  logic [1:0]         sync_r;
  logic               lock_s;
  logic               lost_r, lost_set_s;
  logic               pll_rst_r, dom_rst_r, locked_r, fail_r;
  logic               pll_rst_nx_s, dom_rst_nx_s, fail_nx_s;

  assign lock_s = sync_r[1];

  // Next state and counters; restart overrides every other transition.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    retry_nx_s = retry_r;
    lost_set_s = 1'b0;
    if (retry_r == RETRY_SAT) begin
      retry_inc_s = RETRY_SAT;
    end else begin
      retry_inc_s = retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
    end
    if (restart) begin
      state_nx_s = ST_RESET;
      cnt_nx_s   = CNT_ZERO;
      retry_nx_s = {RETRY_W{1'b0}};
    end else begin
      case (state_r)
        ST_RESET: begin
          if (cnt_r == RST_LAST) begin
            state_nx_s = ST_WAIT_LOCK;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nx_s = ST_DEBOUNCE;
            cnt_nx_s   = CNT_ZERO;
          end else if (cnt_r == TO_LAST) begin
            retry_nx_s = retry_inc_s;
            cnt_nx_s   = CNT_ZERO;
            if (retry_inc_s >= RETRY_LIM) begin
              state_nx_s = ST_FAIL;
            end else begin
              state_nx_s = ST_RESET;
            end
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        ST_DEBOUNCE: begin
          if (!lock_s) begin
            state_nx_s = ST_WAIT_LOCK;
            cnt_nx_s   = CNT_ZERO;
          end else if (cnt_r == DEB_LAST) begin
            state_nx_s = ST_RUN;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nx_s = ST_RESET;
            cnt_nx_s   = CNT_ZERO;
            lost_set_s = 1'b1;
          end else if (cnt_r == REL_CNT) begin
            cnt_nx_s = cnt_r;
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        ST_FAIL: begin
          cnt_nx_s = CNT_ZERO;
        end
        default: begin
          state_nx_s = ST_RESET;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the next state so the outputs can be registered without lag.
  always_comb begin
    pll_rst_nx_s = 1'b1;
    dom_rst_nx_s = 1'b1;
    fail_nx_s    = 1'b0;
    case (state_nx_s)
      ST_RESET: begin
        pll_rst_nx_s = 1'b1;
      end
      ST_WAIT_LOCK, ST_DEBOUNCE: begin
        pll_rst_nx_s = 1'b0;
      end
      ST_RUN: begin
        pll_rst_nx_s = 1'b0;
        dom_rst_nx_s = (cnt_nx_s != REL_CNT);
      end
      ST_FAIL: begin
        fail_nx_s = 1'b1;
      end
      default: begin
        pll_rst_nx_s = 1'b1;
      end
    endcase
  end

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RESET;
      cnt_r     <= CNT_ZERO;
      retry_r   <= {RETRY_W{1'b0}};
      sync_r    <= 2'b00;
      lost_r    <= 1'b0;
      pll_rst_r <= 1'b1;
      dom_rst_r <= 1'b1;
      locked_r  <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      retry_r   <= retry_nx_s;
      sync_r    <= {sync_r[0], lock_raw};
      lost_r    <= lost_set_s | (lost_r & ~lost_clr);
      pll_rst_r <= pll_rst_nx_s;
      dom_rst_r <= dom_rst_nx_s;
      locked_r  <= ~dom_rst_nx_s;
      fail_r    <= fail_nx_s;
    end
  end

  assign pll_rst_o  = pll_rst_r;
  assign domain_rst = dom_rst_r;
  assign locked     = locked_r;
  assign locked_nx  = ~dom_rst_nx_s;
  assign lock_lost  = lost_r;
  assign fail       = fail_r;
  assign retry_cnt  = retry_r;

endmodule

// File: rtl/pll_lock_seq.sv
// Lock supervisor and domain-reset sequencer for N_PLL independent PLL wrappers,
// running on the free-running reference clock.
module pll_lock_seq
  import pll_lock_pkg::*;
#(
  parameter int N_PLL        = 2,
  parameter int RST_CYCLES   = 32,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int DEBOUNCE     = 1024,
  parameter int RELEASE_DLY  = 16,
  parameter int MAX_RETRY    = 7
) (
  input  logic                       clkin1,
  input  logic                       pll_rst,
  input  logic [N_PLL-1:0]           pll_lock,
  input  logic [N_PLL-1:0]           restart,
  input  logic                       lost_clr,
  output logic [N_PLL-1:0]           pll_rst_o,
  output logic [N_PLL-1:0]           domain_rst,
  output logic [N_PLL-1:0]           locked,
  output logic                       all_locked,
  output logic [N_PLL-1:0]           lock_lost,
  output logic [N_PLL-1:0]           fail,
  output logic [RETRY_W*N_PLL-1:0]   retry_cnt
);

  logic [N_PLL-1:0] locked_nx_s;
  logic             all_locked_r;

  for (genvar i = 0; i < N_PLL; i++) begin : g_chan
    pll_lock_chan #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .DEBOUNCE     (DEBOUNCE),
      .RELEASE_DLY  (RELEASE_DLY),
      .MAX_RETRY    (MAX_RETRY)
    ) u_chan (
      .clk        (clkin1),
      .rst        (pll_rst),
      .lock_raw   (pll_lock[i]),
      .restart    (restart[i]),
      .lost_clr   (lost_clr),
      .pll_rst_o  (pll_rst_o[i]),
      .domain_rst (domain_rst[i]),
      .locked     (locked[i]),
      .locked_nx  (locked_nx_s[i]),
      .lock_lost  (lock_lost[i]),
      .fail       (fail[i]),
      .retry_cnt  (retry_cnt[RETRY_W*i +: RETRY_W])
    );
  end

  // Registered from the channels' next-cycle locked so it tracks locked exactly.
  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      all_locked_r <= 1'b0;
    end else begin
      all_locked_r <= &locked_nx_s;
    end
  end

  assign all_locked = all_locked_r;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: a table of {inputs, hold cycles, expected outputs}
// followed by hand-written sequences for glitch, restart priority and mid-run reset.
module tb_pll_lock_seq;

  logic       clkin1 = 1'b0;
  logic       pll_rst;
  logic [1:0] pll_lock;
  logic [1:0] restart;
  logic       lost_clr;
  logic [1:0] pll_rst_o, domain_rst, locked, lock_lost, fail;
  logic       all_locked;
  logic [7:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clkin1 = ~clkin1;

  pll_lock_seq #(
    .N_PLL(2), .RST_CYCLES(4), .LOCK_TIMEOUT(20), .DEBOUNCE(8), .RELEASE_DLY(3), .MAX_RETRY(2)
  ) dut (
    .clkin1(clkin1), .pll_rst(pll_rst), .pll_lock(pll_lock), .restart(restart),
    .lost_clr(lost_clr), .pll_rst_o(pll_rst_o), .domain_rst(domain_rst), .locked(locked),
    .all_locked(all_locked), .lock_lost(lock_lost), .fail(fail), .retry_cnt(retry_cnt)
  );

  typedef struct {
    logic       rst;
    logic [1:0] lock;
    logic [1:0] rs;
    logic       clr;
    int         n;
    logic [1:0] pr, dr, lk;
    logic       al;
    logic [1:0] ll, fl;
    logic [7:0] rc;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(input logic rst, input logic [1:0] lock, input logic [1:0] rs,
                              input logic clr, input int n, input logic [1:0] pr,
                              input logic [1:0] dr, input logic [1:0] lk, input logic al,
                              input logic [1:0] ll, input logic [1:0] fl, input logic [7:0] rc);
    vec_t v;
    v.rst = rst; v.lock = lock; v.rs = rs; v.clr = clr; v.n = n;
    v.pr = pr; v.dr = dr; v.lk = lk; v.al = al; v.ll = ll; v.fl = fl; v.rc = rc;
    return v;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin1);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] pr, input logic [1:0] dr,
                         input logic [1:0] lk, input logic al, input logic [1:0] ll,
                         input logic [1:0] fl, input logic [7:0] rc);
    chk($sformatf("%s pll_rst_o", tag),  {6'd0, pll_rst_o},  {6'd0, pr});
    chk($sformatf("%s domain_rst", tag), {6'd0, domain_rst}, {6'd0, dr});
    chk($sformatf("%s locked", tag),     {6'd0, locked},     {6'd0, lk});
    chk($sformatf("%s all_locked", tag), {7'd0, all_locked}, {7'd0, al});
    chk($sformatf("%s lock_lost", tag),  {6'd0, lock_lost},  {6'd0, ll});
    chk($sformatf("%s fail", tag),       {6'd0, fail},       {6'd0, fl});
    chk($sformatf("%s retry_cnt", tag),  retry_cnt,          rc);
  endtask

  task automatic drive(input logic rst, input logic [1:0] lock, input logic [1:0] rs,
                       input logic clr);
    pll_rst  = rst;
    pll_lock = lock;
    restart  = rs;
    lost_clr = clr;
  endtask

  initial begin
    drive(1'b1, 2'b00, 2'b00, 1'b0);

    //            rst   lock   rst   clr  n   pr     dr     lk     al    ll     fl     rc
    vt[0]  = mk(1'b1, 2'b00, 2'b00, 1'b0, 3, 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[1]  = mk(1'b0, 2'b00, 2'b00, 1'b0, 3, 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[2]  = mk(1'b0, 2'b00, 2'b00, 1'b0, 1, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[3]  = mk(1'b0, 2'b00, 2'b00, 1'b0, 2, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[4]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 13, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[5]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00);
    vt[6]  = mk(1'b0, 2'b10, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00);
    vt[7]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00);
    vt[8]  = mk(1'b0, 2'b11, 2'b00, 1'b1, 1, 2'b01, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h00);
    vt[9]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 3, 2'b01, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h00);
    vt[10] = mk(1'b0, 2'b11, 2'b00, 1'b0, 1, 2'b00, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h00);
    vt[11] = mk(1'b0, 2'b11, 2'b00, 1'b1, 1, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[12] = mk(1'b0, 2'b11, 2'b00, 1'b0, 10, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[13] = mk(1'b0, 2'b11, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00);
    vt[14] = mk(1'b0, 2'b10, 2'b00, 1'b0, 3, 2'b01, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h00);
    vt[15] = mk(1'b0, 2'b10, 2'b00, 1'b0, 23, 2'b00, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h00);
    vt[16] = mk(1'b0, 2'b10, 2'b00, 1'b0, 1, 2'b01, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h01);
    vt[17] = mk(1'b0, 2'b10, 2'b00, 1'b0, 23, 2'b00, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h01);
    vt[18] = mk(1'b0, 2'b10, 2'b00, 1'b0, 1, 2'b01, 2'b01, 2'b10, 1'b0, 2'b01, 2'b01, 8'h02);
    vt[19] = mk(1'b0, 2'b10, 2'b00, 1'b0, 5, 2'b01, 2'b01, 2'b10, 1'b0, 2'b01, 2'b01, 8'h02);
    vt[20] = mk(1'b0, 2'b10, 2'b01, 1'b0, 1, 2'b01, 2'b01, 2'b10, 1'b0, 2'b01, 2'b00, 8'h00);
    vt[21] = mk(1'b0, 2'b11, 2'b00, 1'b1, 1, 2'b01, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[22] = mk(1'b0, 2'b11, 2'b00, 1'b0, 14, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h00);
    vt[23] = mk(1'b0, 2'b11, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00);

    for (int k = 0; k < 24; k++) begin
      drive(vt[k].rst, vt[k].lock, vt[k].rs, vt[k].clr);
      step(vt[k].n);
      chk_all($sformatf("vec%0d", k), vt[k].pr, vt[k].dr, vt[k].lk, vt[k].al,
              vt[k].ll, vt[k].fl, vt[k].rc);
    end

    // Glitchy lock on channel 1: 5 high, 1 low, then high restarts the debounce.
    drive(1'b1, 2'b01, 2'b00, 1'b0);
    step(2);
    chk_all("rst2", 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);
    drive(1'b0, 2'b01, 2'b00, 1'b0);
    step(4);
    chk_all("glitch_wait", 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);
    pll_lock = 2'b11;
    step(5);
    pll_lock = 2'b01;
    step(1);
    pll_lock = 2'b11;
    step(6);
    chk_all("glitch_ch0", 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 8'h00);
    step(2);
    chk_all("glitch_nolock", 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 8'h00);
    step(5);
    chk_all("glitch_pre", 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 8'h00);
    step(1);
    chk_all("glitch_lock", 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00);

    // Restart on channel 1 in the same cycle its lock drop reaches the FSM.
    pll_lock = 2'b01;
    step(2);
    chk_all("rs_pre", 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00);
    restart = 2'b10;
    step(1);
    chk_all("rs_prio", 2'b10, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 8'h00);

    // Channel 0 loses lock, channel 1 relocks; reset lands while channel 1 debounces.
    restart  = 2'b00;
    pll_lock = 2'b10;
    step(1);
    chk_all("rs_after", 2'b10, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 8'h00);
    step(6);
    chk_all("mid_pre", 2'b00, 2'b11, 2'b00, 1'b0, 2'b01, 2'b00, 8'h00);
    pll_rst = 1'b1;
    step(1);
    chk_all("mid_rst", 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
